// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared DHT11 timing constants, frame size and state encoding
package dht11_pkg;

    localparam int DHT_START_MIN_US  = 18000;
    localparam int DHT_RESP_DELAY_US = 30;
    localparam int DHT_RESP_LOW_US   = 80;
    localparam int DHT_RESP_HIGH_US  = 80;
    localparam int DHT_BIT_LOW_US    = 50;
    localparam int DHT_BIT0_HIGH_US  = 26;
    localparam int DHT_BIT1_HIGH_US  = 70;

    localparam int FRAME_BITS = 40;
    localparam int CNT_W      = 16;
    localparam int IDX_W      = 6;

    // Four bits leave spare codes so a corrupted register can be steered back to IDLE.
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_MEAS_LOW  = 4'd1;
    localparam state_t ST_RESP_WAIT = 4'd2;
    localparam state_t ST_RESP_LOW  = 4'd3;
    localparam state_t ST_RESP_HIGH = 4'd4;
    localparam state_t ST_BIT_LOW   = 4'd5;
    localparam state_t ST_BIT_HIGH  = 4'd6;
    localparam state_t ST_END_LOW   = 4'd7;

    function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// rtl/dht11_responder_if.sv - data bytes in, frame status out for the DHT11 responder
interface dht11_responder_if;

    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       busy;
    logic       frame_done;

    modport master (
        output hum_int, hum_dec, temp_int, temp_dec,
        input  busy, frame_done
    );

    modport slave (
        input  hum_int, hum_dec, temp_int, temp_dec,
        output busy, frame_done
    );

endinterface

// File: rtl/dht11_us_tick.sv
// rtl/dht11_us_tick.sv - 1 us tick prescaler, restartable so every phase starts on a clean boundary
module dht11_us_tick #(
    parameter int CLKS_PER_US = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (restart || pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == LAST);

endmodule

// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 device-side emulator: start detection, response preamble, 40-bit frame
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLKS_PER_US   = 1,
    parameter int START_MIN_US  = DHT_START_MIN_US,
    parameter int RESP_DELAY_US = DHT_RESP_DELAY_US,
    parameter int RESP_LOW_US   = DHT_RESP_LOW_US,
    parameter int RESP_HIGH_US  = DHT_RESP_HIGH_US,
    parameter int BIT_LOW_US    = DHT_BIT_LOW_US,
    parameter int BIT0_HIGH_US  = DHT_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US  = DHT_BIT1_HIGH_US
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               dht_data,
    dht11_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_MIN_US - 1);
    localparam logic [CNT_W-1:0] START_SAT  = CNT_W'(START_MIN_US);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RESP_DELAY_US - 1);
    localparam logic [CNT_W-1:0] RLOW_LAST  = CNT_W'(RESP_LOW_US - 1);
    localparam logic [CNT_W-1:0] RHIGH_LAST = CNT_W'(RESP_HIGH_US - 1);
    localparam logic [CNT_W-1:0] BLOW_LAST  = CNT_W'(BIT_LOW_US - 1);
    localparam logic [CNT_W-1:0] B0_LAST    = CNT_W'(BIT0_HIGH_US - 1);
    localparam logic [CNT_W-1:0] B1_LAST    = CNT_W'(BIT1_HIGH_US - 1);
    localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(FRAME_BITS - 1);

    state_t                state;
    state_t                state_n;
    logic                  sync1;
    logic                  sync2;
    logic                  line;
    logic                  tick;
    logic                  restart;
    logic                  phase_end;
    logic                  start_ok;
    logic                  drive_low;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      phase_last;
    logic [IDX_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic                  busy_q;
    logic                  done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= dht_data;
            sync2 <= sync1;
        end
    end

    assign line = sync2;

    dht11_us_tick #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        phase_last = BLOW_LAST;
        case (state)
            ST_RESP_WAIT: phase_last = WAIT_LAST;
            ST_RESP_LOW:  phase_last = RLOW_LAST;
            ST_RESP_HIGH: phase_last = RHIGH_LAST;
            ST_BIT_HIGH:  phase_last = shreg[FRAME_BITS-1] ? B1_LAST : B0_LAST;
            default:      phase_last = BLOW_LAST;
        endcase
    end

    assign phase_end = tick && (cnt == phase_last);
    // The IDLE cycle that saw the falling edge is the first microsecond of the pulse.
    assign start_ok  = (cnt >= START_LAST);
    assign restart   = (state_n != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:      if (!line)     state_n = ST_MEAS_LOW;
            ST_MEAS_LOW:  if (line)      state_n = start_ok ? ST_RESP_WAIT : ST_IDLE;
            ST_RESP_WAIT: if (phase_end) state_n = ST_RESP_LOW;
            ST_RESP_LOW:  if (phase_end) state_n = ST_RESP_HIGH;
            ST_RESP_HIGH: if (phase_end) state_n = ST_BIT_LOW;
            ST_BIT_LOW:   if (phase_end) state_n = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (phase_end) state_n = (bit_idx == LAST_BIT) ? ST_END_LOW : ST_BIT_LOW;
            ST_END_LOW:   if (phase_end) state_n = ST_IDLE;
            default:                     state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        drive_low = 1'b0;
        case (state)
            ST_RESP_LOW, ST_BIT_LOW, ST_END_LOW: drive_low = 1'b1;
            default:                             drive_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (restart) begin
                cnt <= '0;
            end else if (state != ST_IDLE && tick &&
                         !(state == ST_MEAS_LOW && cnt == START_SAT)) begin
                cnt <= cnt + 1'b1;
            end

            if (state == ST_MEAS_LOW && state_n == ST_RESP_WAIT) begin
                shreg  <= {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                           checksum(bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec)};
                busy_q <= 1'b1;
            end

            if (state == ST_RESP_HIGH && phase_end) begin
                bit_idx <= '0;
            end

            if (state == ST_BIT_HIGH && phase_end) begin
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                bit_idx <= bit_idx + 1'b1;
            end

            if (state == ST_END_LOW && phase_end) begin
                done_q <= 1'b1;
            end

            // Also clears busy when a bad state code falls back to IDLE.
            if (state_n == ST_IDLE) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign dht_data       = drive_low ? 1'b0 : 1'bz;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - directed bench: host start pulses, frame decode and phase timing per instance
module tb_dht11_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_low;
    int         sel;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    wire        line0, line1, line2;
    logic       line_s, busy_s, done_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cpu, t_delay, t_rlow, t_rhigh, t_blow, t_b0, t_b1;

    always #5 clk = ~clk;

    pullup (line0);
    pullup (line1);
    pullup (line2);
    assign line0 = (host_low && sel == 0) ? 1'b0 : 1'bz;
    assign line1 = (host_low && sel == 1) ? 1'b0 : 1'bz;
    assign line2 = (host_low && sel == 2) ? 1'b0 : 1'bz;

    dht11_responder_if bus0 ();
    dht11_responder_if bus1 ();
    dht11_responder_if bus2 ();

    assign bus0.hum_int = hum_int;  assign bus0.hum_dec = hum_dec;
    assign bus0.temp_int = temp_int; assign bus0.temp_dec = temp_dec;
    assign bus1.hum_int = hum_int;  assign bus1.hum_dec = hum_dec;
    assign bus1.temp_int = temp_int; assign bus1.temp_dec = temp_dec;
    assign bus2.hum_int = hum_int;  assign bus2.hum_dec = hum_dec;
    assign bus2.temp_int = temp_int; assign bus2.temp_dec = temp_dec;

    dht11_responder u0 (.clk(clk), .rst(rst), .dht_data(line0), .bus(bus0));

    dht11_responder #(.START_MIN_US(100)) u1 (.clk(clk), .rst(rst), .dht_data(line1), .bus(bus1));

    dht11_responder #(
        .CLKS_PER_US(50), .START_MIN_US(10), .RESP_DELAY_US(3), .RESP_LOW_US(4),
        .RESP_HIGH_US(4), .BIT_LOW_US(2), .BIT0_HIGH_US(1), .BIT1_HIGH_US(3)
    ) u2 (.clk(clk), .rst(rst), .dht_data(line2), .bus(bus2));

    always_comb begin
        case (sel)
            0:       begin line_s = line0; busy_s = bus0.busy; done_s = bus0.frame_done; end
            1:       begin line_s = line1; busy_s = bus1.busy; done_s = bus1.frame_done; end
            default: begin line_s = line2; busy_s = bus2.busy; done_s = bus2.frame_done; end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic use_dut(input int s);
        sel = s;
        if (s == 2) begin
            cpu = 50; t_delay = 3;  t_rlow = 4;  t_rhigh = 4;  t_blow = 2;  t_b0 = 1;  t_b1 = 3;
        end else begin
            cpu = 1;  t_delay = 30; t_rlow = 80; t_rhigh = 80; t_blow = 50; t_b0 = 26; t_b1 = 70;
        end
    endtask

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
    endtask

    task automatic start_pulse(input int len);
        @(negedge clk);
        host_low = 1'b1;
        repeat (len) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Counts consecutive negedge samples at level lvl; stops on the first differing sample.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (line_s === lvl && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic recv_head(input string tag, input int nbits,
                             output logic [39:0] got, output int bad_t);
        int nl, nh;
        got   = '0;
        bad_t = 0;
        @(negedge clk);
        run_len(1'b1, nl);
        check({tag, ".resp_wait"}, nl, 2 + t_delay * cpu);
        check({tag, ".busy"}, busy_s, 1);
        run_len(1'b0, nl);
        check({tag, ".resp_low"}, nl, t_rlow * cpu);
        run_len(1'b1, nh);
        check({tag, ".resp_high"}, nh, t_rhigh * cpu);
        for (int i = 0; i < nbits; i++) begin
            run_len(1'b0, nl);
            run_len(1'b1, nh);
            if (nl != t_blow * cpu) bad_t++;
            if (nh == t_b1 * cpu) begin
                got = {got[38:0], 1'b1};
            end else begin
                got = {got[38:0], 1'b0};
                if (nh != t_b0 * cpu) bad_t++;
            end
        end
    endtask

    task automatic recv_frame(input string tag, input logic [39:0] exp);
        logic [39:0] got;
        int          bad_t;
        int          n;
        recv_head(tag, 40, got, bad_t);
        check({tag, ".bits"}, got, exp);
        check({tag, ".bit_timing"}, bad_t, 0);
        run_len(1'b0, n);
        check({tag, ".end_low"}, n, t_blow * cpu);
        check({tag, ".done_pulse"}, done_s, 1);
        check({tag, ".busy_clear"}, busy_s, 0);
        @(negedge clk);
        check({tag, ".done_single"}, done_s, 0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [39:0] got;
        int          bad_t;
        int          bad;

        rst      = 1'b1;
        host_low = 1'b0;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        use_dut(0);
        repeat (3) @(negedge clk);
        check("rst.busy", bus0.busy, 0);
        check("rst.done", bus0.frame_done, 0);
        check("rst.line0", line0, 1);
        check("rst.line1", line1, 1);
        check("rst.line2", line2, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Short pulse rejected, exact-minimum pulse accepted.
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        start_pulse(17999);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (line_s !== 1'b1 || busy_s !== 1'b0) bad++;
        end
        check("short.ignored", bad, 0);
        start_pulse(18000);
        recv_frame("t1", 40'h37_00_19_00_50);

        use_dut(1);
        set_bytes(8'hFF, 8'h00, 8'h00, 8'h00);
        start_pulse(100);
        recv_frame("t3", 40'hFF_00_00_00_FF);

        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start_pulse(100);
        recv_frame("t4", 40'hFF_FF_FF_FF_FC);

        set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
        start_pulse(100);
        fork
            begin
                repeat (3) @(negedge clk);
                set_bytes(8'hAA, 8'hBB, 8'hCC, 8'hDD);
            end
        join_none
        recv_frame("t5", 40'h12_34_56_78_14);

        // Reset in the low lead-in of bit 10.
        set_bytes(8'hA5, 8'h5A, 8'h0F, 8'hF0);
        start_pulse(100);
        recv_head("t6", 10, got, bad_t);
        check("t6.head_bits", got[9:0], 10'h295);
        check("t6.head_timing", bad_t, 0);
        repeat (5) @(negedge clk);
        check("t6.bit10_low", line_s, 0);
        rst = 1'b1;
        #1;
        check("t6.rst_release", line_s, 1);
        check("t6.rst_busy", busy_s, 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_s !== 1'b0) bad++;
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_s !== 1'b0 || line_s !== 1'b1) bad++;
        end
        check("t6.no_done", bad, 0);
        set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
        start_pulse(100);
        recv_frame("t6r", 40'h01_02_03_04_0A);

        // Prescaled instance, every phase x50.
        use_dut(2);
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        start_pulse(500);
        recv_frame("t7", 40'h37_00_19_00_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator: the device end of the single-wire DHT11 bus.
- Detects the host start pulse, then drives the response preamble and the 40-bit frame with checksum onto the open-drain data line.
- Used as the bus partner for the start/reader logic, both in simulation and on-board loopback.
- The line is pulled high externally. This block only ever drives 0 or releases (Z).

Parameters:
- CLKS_PER_US, 1, clk cycles per 1 us timing tick. Must be ≥1.
- START_MIN_US, 18000, minimum host low time accepted as a start.
- RESP_DELAY_US, 30, wait after host release before the response.
- RESP_LOW_US, 80, response low phase.
- RESP_HIGH_US, 80, response high (released) phase.
- BIT_LOW_US, 50, low lead-in of every bit and of the end marker.
- BIT0_HIGH_US, 26, released time for a 0 bit.
- BIT1_HIGH_US, 70, released time for a 1 bit.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- dht_data  inout  1  bus line; driven 0 or Z only
- hum_int  input  8  humidity integer byte
- hum_dec  input  8  humidity decimal byte
- temp_int  input  8  temperature integer byte
- temp_dec  input  8  temperature decimal byte
- busy  output  1  high from start acceptance to end of frame
- frame_done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Reset values: dht_data=Z, busy=0, frame_done=0, state=IDLE, counters=0. Reset is asynchronous, so the line is released immediately, including mid-frame.
- Input path: dht_data passes through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle latency).
- Tick: a prescaler issues a 1-cycle tick every CLKS_PER_US cycles. It is restarted at every state entry.
- Phase length N us means exactly N*CLKS_PER_US cycles. The phase counter clears on state entry; the state advances on the tick where counter==N-1.
- States and transitions:
  - IDLE: line released. Synchronized low → MEAS_LOW.
  - MEAS_LOW: count low time; the counter saturates at START_MIN_US.
    - Line high before START_MIN_US → IDLE, no response.
    - Line high with count ≥ START_MIN_US (a pulse of exactly START_MIN_US is accepted) → RESP_WAIT. In the same cycle, latch the 4 data bytes and checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, and set busy=1.
  - RESP_WAIT: released for RESP_DELAY_US → RESP_LOW. Line activity is ignored.
  - RESP_LOW: drive 0 for RESP_LOW_US → RESP_HIGH.
  - RESP_HIGH: release for RESP_HIGH_US → BIT_LOW, bit index 0.
  - BIT_LOW: drive 0 for BIT_LOW_US → BIT_HIGH.
  - BIT_HIGH: release for BIT1_HIGH_US if the bit is 1, else BIT0_HIGH_US.
    - Index < 39 → increment, go to BIT_LOW.
    - Index 39 → END_LOW.
  - END_LOW: drive 0 for BIT_LOW_US → IDLE, release the line, busy=0, frame_done=1 for one cycle.
- Bit order: 40-bit shift register {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
- After acceptance the bus input is ignored until IDLE. Host contention does not alter timing.
- Data byte changes after the latch cycle do not affect the frame in flight.
- Illegal state encodings → IDLE with the line released.
- Back-to-back frames: a new start is detected only from IDLE, i.e. after frame_done.

Decomposition:
- Shared package/header dht11_pkg:
  - Timing constants (18000, 30, 80, 50, 26, 70), shared with the start module and the reader.
  - Frame length 40.
  - State encoding localparams.
- One sub-module, dht11_us_tick: prescaler with a restart input and a tick output.
- Synchronizer and FSM stay in the top module.

Test Plan (CLKS_PER_US=1 unless stated; bench adds a pull-up on dht_data):
1. Host drives low 18000 cycles, then releases; bytes 0x37,0x00,0x19,0x00 → low 80 cycles starts 2+30 cycles after release, then high 80. The 40 decoded bits equal 0x37_00_19_00_50. Final low is 50 cycles, then a frame_done pulse and busy low.
2. Host low 17999 cycles, then release → line never driven, busy stays 0. A following 18000-cycle pulse yields a normal frame.
3. hum_int=0xFF, others 0x00 → first 8 bits high 70 cycles, bits 8-31 high 26 cycles, checksum bits encode 0xFF. Every bit low is exactly 50 cycles.
4. All bytes 0xFF → checksum 0xFC (wrap).
5. Change all data bytes 1 cycle after acceptance → the frame carries the originally latched values.
6. Assert rst during BIT_LOW of bit 10 → dht_data=Z in the same cycle, busy=0, no frame_done. After release, a new start produces a full correct frame. Repeat test 1 with CLKS_PER_US=50: every phase is scaled ×50 exactly.
